// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and constants for the ID-stage branch resolve unit.
package branch_resolve_unit_pkg;

    // Branch controller states: free-running, waiting on operands, deferred resolve.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STALL   = 2'd1,
        RESOLVE = 2'd2
    } state_t;

    localparam int                REG_W     = 5;
    localparam logic [REG_W-1:0]  REG_ZERO  = '0;
    localparam int                BR_SHIFT  = 2;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between the ID stage / pipeline control and the branch resolve unit.
interface branch_resolve_unit_if #(
    parameter int CNT_W = 32
);
    import branch_resolve_unit_pkg::*;

    logic              id_valid;
    logic              id_is_beq;
    logic              id_is_bne;
    logic [31:0]       id_pc_plus4;
    logic [15:0]       id_imm16;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              equal_in;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rd;
    logic              mem_mem_read;
    logic [REG_W-1:0]  mem_rd;

    logic              pc_src;
    logic [31:0]       branch_target;
    logic              if_id_flush;
    logic              pc_write;
    logic              if_id_write;
    logic              id_ex_bubble;
    logic [CNT_W-1:0]  branch_count;
    logic [CNT_W-1:0]  taken_count;

    // Pipeline side: presents the ID/EX/MEM fields, consumes the control outputs.
    modport master (
        output id_valid, id_is_beq, id_is_bne, id_pc_plus4, id_imm16, id_rs, id_rt,
               equal_in, ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
        input  pc_src, branch_target, if_id_flush, pc_write, if_id_write, id_ex_bubble,
               branch_count, taken_count
    );

    // Resolve unit side.
    modport slave (
        input  id_valid, id_is_beq, id_is_bne, id_pc_plus4, id_imm16, id_rs, id_rt,
               equal_in, ex_reg_write, ex_mem_read, ex_rd, mem_mem_read, mem_rd,
        output pc_src, branch_target, if_id_flush, pc_write, if_id_write, id_ex_bubble,
               branch_count, taken_count
    );

endinterface

// File: rtl/branch_resolve_unit_hazard_detect.sv
// Combinational count of stall cycles a branch needs before its operands are forwardable.
module branch_hazard_detect
    import branch_resolve_unit_pkg::*;
#(
    parameter int LOAD_EX_STALLS = 2
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    input  logic             i_ex_reg_write,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic             i_mem_mem_read,
    input  logic [REG_W-1:0] i_mem_rd,
    output logic [1:0]       o_need
);

    // Stall cycles required by one source register; $zero never matches.
    function automatic logic [1:0] src_need(
        input logic [REG_W-1:0] src,
        input logic             ex_write,
        input logic             ex_load,
        input logic [REG_W-1:0] ex_rd,
        input logic             mem_load,
        input logic [REG_W-1:0] mem_rd
    );
        logic       ex_hit;
        logic       mem_hit;
        logic [1:0] n;
        ex_hit  = (src == ex_rd)  && (src != REG_ZERO);
        mem_hit = (src == mem_rd) && (src != REG_ZERO);
        n = 2'd0;
        if (mem_hit && mem_load)             n = 2'd1;
        if (ex_hit && ex_write && !ex_load)  n = 2'd1;
        if (ex_hit && ex_load)               n = 2'(LOAD_EX_STALLS);
        return n;
    endfunction

    logic [1:0] w_need_rs;
    logic [1:0] w_need_rt;

    // Take the worse of the two operands.
    always_comb begin
        w_need_rs = src_need(i_rs, i_ex_reg_write, i_ex_mem_read, i_ex_rd, i_mem_mem_read, i_mem_rd);
        w_need_rt = src_need(i_rt, i_ex_reg_write, i_ex_mem_read, i_ex_rd, i_mem_mem_read, i_mem_rd);
        o_need    = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage beq/bne resolution, operand-hazard stall control and branch statistics.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int CNT_W          = 32,
    parameter int LOAD_EX_STALLS = 2
) (
    input  logic                  clock,
    input  logic                  reset_n,
    branch_resolve_unit_if.slave  bus
);

    state_t            r_state;
    state_t            w_state_n;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_n;
    logic [CNT_W-1:0]  r_branch_count;
    logic [CNT_W-1:0]  r_taken_count;

    logic [1:0]        w_need;
    logic              w_is_br;
    logic              w_taken;
    logic              w_resolve;
    logic              w_stall;
    logic              w_resolve_q;
    logic              w_stall_q;

    branch_hazard_detect #(
        .LOAD_EX_STALLS (LOAD_EX_STALLS)
    ) u_hazard (
        .i_rs           (bus.id_rs),
        .i_rt           (bus.id_rt),
        .i_ex_reg_write (bus.ex_reg_write),
        .i_ex_mem_read  (bus.ex_mem_read),
        .i_ex_rd        (bus.ex_rd),
        .i_mem_mem_read (bus.mem_mem_read),
        .i_mem_rd       (bus.mem_rd),
        .o_need         (w_need)
    );

    assign w_is_br = bus.id_valid & (bus.id_is_beq | bus.id_is_bne);
    // beq wins if both decode flags are set.
    assign w_taken = bus.id_is_beq ? bus.equal_in : (bus.id_is_bne & ~bus.equal_in);

    // Next-state, stall-counter and resolve/stall decisions.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_resolve = 1'b0;
        w_stall   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_is_br) begin
                    if (w_need == 2'd0) begin
                        w_resolve = 1'b1;
                    end else begin
                        w_stall   = 1'b1;
                        w_cnt_n   = w_need - 2'd1;
                        w_state_n = (w_need > 2'd1) ? STALL : RESOLVE;
                    end
                end
            end
            STALL: begin
                if (!bus.id_valid) begin
                    w_state_n = IDLE;
                    w_cnt_n   = 2'd0;
                end else begin
                    w_stall = 1'b1;
                    if (r_cnt == 2'd1) w_state_n = RESOLVE;
                    else               w_cnt_n   = r_cnt - 2'd1;
                end
            end
            RESOLVE: begin
                w_state_n = IDLE;
                w_resolve = bus.id_valid;
            end
            default: w_state_n = IDLE;
        endcase
    end

    // Outputs fall back to their reset values while reset is held, without waiting for a clock.
    assign w_resolve_q = w_resolve & reset_n;
    assign w_stall_q   = w_stall & reset_n;

    // State, stall counter and saturating statistics.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_cnt          <= 2'd0;
            r_branch_count <= '0;
            r_taken_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from pre-edge values.
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_resolve_q) begin
                if (r_branch_count != '1)           r_branch_count <= r_branch_count + CNT_W'(1);
                if (w_taken && r_taken_count != '1) r_taken_count  <= r_taken_count + CNT_W'(1);
            end
        end
    end

    assign bus.branch_target = bus.id_pc_plus4
                             + ({{16{bus.id_imm16[15]}}, bus.id_imm16} << BR_SHIFT);
    assign bus.pc_src        = w_resolve_q & w_taken;
    assign bus.if_id_flush   = w_resolve_q & w_taken;
    assign bus.pc_write      = ~w_stall_q;
    assign bus.if_id_write   = ~w_stall_q;
    assign bus.id_ex_bubble  = w_stall_q;
    assign bus.branch_count  = r_branch_count;
    assign bus.taken_count   = r_taken_count;

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage branch decision and hazard-stall controller for the 5-stage MIPS pipeline.
- Sits directly downstream of the ID register-equality comparator and consumes its equal flag, so beq/bne resolve in ID.
- Drives the IF PC mux, the IF/ID flush and the pipeline stall enables.
- Stalls the branch in ID until its operands are forwardable; keeps branch/taken performance counters.

Parameters:
- CNT_W, 32, width of the saturating performance counters.
- LOAD_EX_STALLS, 2, stall cycles when a branch operand is the destination of a load currently in EX.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_is_beq  in  1  ID instruction is beq.
- id_is_bne  in  1  ID instruction is bne.
- id_pc_plus4  in  32  PC+4 of the ID instruction.
- id_imm16  in  16  branch offset field.
- id_rs, id_rt  in  5  branch source registers.
- equal_in  in  1  comparator result (rs == rt), forwarded values.
- ex_reg_write, ex_mem_read  in  1  EX-stage write/load flags.
- ex_rd  in  5  EX destination register.
- mem_mem_read  in  1  MEM-stage load flag.
- mem_rd  in  5  MEM destination register.
- pc_src  out  1  1 = select branch_target.
- branch_target  out  32  computed target.
- if_id_flush  out  1  squash the IF/ID register.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  insert a NOP into ID/EX.
- branch_count  out  CNT_W  resolved branches.
- taken_count  out  CNT_W  taken branches.

Behaviour:
- Operand-match rule: a source register matches a destination only if it equals that destination and is non-zero. $zero never creates a hazard.
- is_br = id_valid & (id_is_beq | id_is_bne).
- need = max over rs/rt of:
  - EX match with ex_mem_read: LOAD_EX_STALLS.
  - EX match with ex_reg_write and not a load: 1.
  - MEM match with mem_mem_read: 1.
  - otherwise 0.
- FSM states: IDLE, STALL, RESOLVE. Stall counter is 2 bits.
- IDLE:
  - If is_br and need == 0: resolve this cycle combinationally; stay in IDLE.
  - If is_br and need > 0: cnt <= need-1; go to STALL if need > 1, else RESOLVE. Stall outputs are asserted this cycle.
- STALL: stall outputs asserted. If cnt == 1, go to RESOLVE, else cnt <= cnt-1.
- RESOLVE: resolve unconditionally, with no hazard re-check; return to IDLE.
- Stall outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, pc_src=0, if_id_flush=0.
- Resolve:
  - taken = (id_is_beq & equal_in) | (id_is_bne & ~equal_in).
  - pc_src = taken, if_id_flush = taken, pc_write=1, if_id_write=1, id_ex_bubble=0.
  - Taken penalty is exactly one cycle.
- Outputs in any non-resolve, non-stall cycle: pc_src=0, if_id_flush=0, pc_write=1, if_id_write=1, id_ex_bubble=0.
- branch_target is combinational and always driven:
  - branch_target = id_pc_plus4 + (sign_extend(id_imm16) << 2), modulo 2^32 (wraps, no overflow flag).
  - Valid only when pc_src=1.
- Counters update on each resolve cycle:
  - branch_count += 1.
  - taken_count += taken.
  - Both saturate at all-ones.
- Boundaries:
  - id_valid drops in STALL or RESOLVE: abort to IDLE; no resolve, no counter update.
  - beq and bne asserted together is illegal; beq takes priority.
  - Reset mid-stall returns to IDLE immediately.
- Reset values:
  - state=IDLE, cnt=0, counters=0.
  - Outputs: pc_src=0, if_id_flush=0, pc_write=1, if_id_write=1, id_ex_bubble=0.

Decomposition:
- Shared package holds:
  - State enum (IDLE, STALL, RESOLVE).
  - Register-index width constant (5).
  - REG_ZERO constant.
  - Branch-offset shift constant (2).
- Natural sub-module: branch_hazard_detect, a combinational block computing need from the source/destination fields.
- FSM, target adder and counters stay in the top module.

Test Plan:
- beq, rs=rt=$t1, equal_in=1, no hazards, pc_plus4=0x00400010, imm=0x0004 -> same cycle: pc_src=1, if_id_flush=1, branch_target=0x00400020; branch_count=1, taken_count=1.
- bne, equal_in=1, imm=0xFFFF -> pc_src=0, if_id_flush=0; branch_count increments, taken_count unchanged; branch_target=0x0040000C.
- beq rs=$8 with EX lw rd=$8 -> 2 cycles of pc_write=0, if_id_write=0, id_ex_bubble=1; resolve in cycle 3 using that cycle's equal_in.
- beq rt=$9 with EX add rd=$9 -> 1 stall cycle, then resolve. Same instruction with rd=$0 -> no stall.
- id_valid deasserted in the second STALL cycle -> next cycle IDLE, outputs at defaults, counters unchanged. reset_n pulsed low mid-stall -> outputs reset immediately, without waiting for a clock edge.
- Force branch_count to all-ones and resolve one more branch -> branch_count stays all-ones. pc_plus4=0xFFFFFFFC, imm=0x0001 -> branch_target=0x00000000.
